// File: rtl/holy_axi_lite_arbiter_pkg.sv
// Shared types for the 2-to-1 AXI-Lite arbiter: FSM states, bus widths and
// packed views of the master-driven (request) and slave-driven (response)
// halves of an AXI-Lite port.
package holy_core_pkg;

   localparam int unsigned AXIL_ADDR_W = 32;
   localparam int unsigned AXIL_DATA_W = 32;
   localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_RD_ADDR,
      ARB_RD_DATA,
      ARB_WR_ADDR,
      ARB_WR_DATA,
      ARB_WR_RESP
   } arb_state_t;

   // Signals driven by an AXI-Lite master, MSB first
   typedef struct packed {
      logic                   awvalid;
      logic [AXIL_ADDR_W-1:0] awaddr;
      logic                   wvalid;
      logic [AXIL_DATA_W-1:0] wdata;
      logic [AXIL_STRB_W-1:0] wstrb;
      logic                   bready;
      logic                   arvalid;
      logic [AXIL_ADDR_W-1:0] araddr;
      logic                   rready;
   } axil_req_t;

   // Signals driven by an AXI-Lite slave, MSB first
   typedef struct packed {
      logic                   awready;
      logic                   wready;
      logic                   bvalid;
      logic [1:0]             bresp;
      logic                   arready;
      logic                   rvalid;
      logic [AXIL_DATA_W-1:0] rdata;
      logic [1:0]             rresp;
   } axil_rsp_t;

   // First channel to serve for a freshly granted master
   function automatic arb_state_t first_txn_state(input logic arvalid,
                                                  input logic awvalid,
                                                  input logic read_first);
      if (arvalid && (!awvalid || read_first)) begin
         return ARB_RD_ADDR;
      end
      return ARB_WR_ADDR;
   endfunction

endpackage

// File: rtl/holy_axi_lite_arbiter_if.sv
// AXI-Lite bus bundle. "master" is the view of the side issuing requests,
// "slave" the view of the side answering them.
interface axi_lite_if;
   import holy_core_pkg::*;

   logic                   awvalid;
   logic                   awready;
   logic [AXIL_ADDR_W-1:0] awaddr;
   logic                   wvalid;
   logic                   wready;
   logic [AXIL_DATA_W-1:0] wdata;
   logic [AXIL_STRB_W-1:0] wstrb;
   logic                   bvalid;
   logic                   bready;
   logic [1:0]             bresp;
   logic                   arvalid;
   logic                   arready;
   logic [AXIL_ADDR_W-1:0] araddr;
   logic                   rvalid;
   logic                   rready;
   logic [AXIL_DATA_W-1:0] rdata;
   logic [1:0]             rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/holy_axi_lite_arbiter_rr_picker.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that did not win last time.
module holy_rr_picker (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       winner_o,
   output logic       any_req_o
);

   // Pure combinational selection
   always_comb begin
      any_req_o = |req_i;
      winner_o  = 1'b0;
      case (req_i)
         2'b01:   winner_o = 1'b0;
         2'b10:   winner_o = 1'b1;
         2'b11:   winner_o = ~last_grant_i;
         default: winner_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/holy_axi_lite_arbiter.sv
// 2-to-1 AXI-Lite arbiter with a single transaction in flight. One grant
// covers reads and writes; channels of the granted port are forwarded
// combinationally according to the FSM state, the idle port sees zeros.
module holy_axi_lite_arbiter
   import holy_core_pkg::*;
#(
   parameter bit READ_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   axi_lite_if.slave        s0_axi_lite,
   axi_lite_if.slave        s1_axi_lite,
   axi_lite_if.master       m_axi_lite,
   output logic [1:0]       grant_o,
   output logic             busy_o
);

   arb_state_t state_q;
   logic       grant_q;
   logic       last_grant_q;
   logic       busy_q;
   logic [1:0] grant_oh_q;

   axil_req_t  s0_req, s1_req, sel_req, m_req;
   axil_rsp_t  m_rsp, g_rsp, s0_rsp, s1_rsp;

   logic       pick_winner;
   logic       pick_any;
   logic       win_arvalid;
   logic       win_awvalid;
   logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

   // Packed views of the interface ports
   assign s0_req = {s0_axi_lite.awvalid, s0_axi_lite.awaddr, s0_axi_lite.wvalid,
                    s0_axi_lite.wdata, s0_axi_lite.wstrb, s0_axi_lite.bready,
                    s0_axi_lite.arvalid, s0_axi_lite.araddr, s0_axi_lite.rready};
   assign s1_req = {s1_axi_lite.awvalid, s1_axi_lite.awaddr, s1_axi_lite.wvalid,
                    s1_axi_lite.wdata, s1_axi_lite.wstrb, s1_axi_lite.bready,
                    s1_axi_lite.arvalid, s1_axi_lite.araddr, s1_axi_lite.rready};
   assign m_rsp  = {m_axi_lite.awready, m_axi_lite.wready, m_axi_lite.bvalid,
                    m_axi_lite.bresp, m_axi_lite.arready, m_axi_lite.rvalid,
                    m_axi_lite.rdata, m_axi_lite.rresp};

   assign {m_axi_lite.awvalid, m_axi_lite.awaddr, m_axi_lite.wvalid,
           m_axi_lite.wdata, m_axi_lite.wstrb, m_axi_lite.bready,
           m_axi_lite.arvalid, m_axi_lite.araddr, m_axi_lite.rready} = m_req;
   assign {s0_axi_lite.awready, s0_axi_lite.wready, s0_axi_lite.bvalid,
           s0_axi_lite.bresp, s0_axi_lite.arready, s0_axi_lite.rvalid,
           s0_axi_lite.rdata, s0_axi_lite.rresp} = s0_rsp;
   assign {s1_axi_lite.awready, s1_axi_lite.wready, s1_axi_lite.bvalid,
           s1_axi_lite.bresp, s1_axi_lite.arready, s1_axi_lite.rvalid,
           s1_axi_lite.rdata, s1_axi_lite.rresp} = s1_rsp;

   holy_rr_picker u_picker (
      .req_i        ({s1_req.arvalid | s1_req.awvalid, s0_req.arvalid | s0_req.awvalid}),
      .last_grant_i (last_grant_q),
      .winner_o     (pick_winner),
      .any_req_o    (pick_any)
   );

   assign win_arvalid = pick_winner ? s1_req.arvalid : s0_req.arvalid;
   assign win_awvalid = pick_winner ? s1_req.awvalid : s0_req.awvalid;
   assign sel_req     = grant_q ? s1_req : s0_req;

   // Forward only the channel the current state owns; everything else is zero
   always_comb begin
      m_req = '0;
      g_rsp = '0;
      unique case (state_q)
         ARB_RD_ADDR: begin
            m_req.arvalid = sel_req.arvalid;
            m_req.araddr  = sel_req.araddr;
            g_rsp.arready = m_rsp.arready;
         end
         ARB_RD_DATA: begin
            m_req.rready  = sel_req.rready;
            g_rsp.rvalid  = m_rsp.rvalid;
            g_rsp.rdata   = m_rsp.rdata;
            g_rsp.rresp   = m_rsp.rresp;
         end
         ARB_WR_ADDR: begin
            m_req.awvalid = sel_req.awvalid;
            m_req.awaddr  = sel_req.awaddr;
            g_rsp.awready = m_rsp.awready;
         end
         ARB_WR_DATA: begin
            m_req.wvalid  = sel_req.wvalid;
            m_req.wdata   = sel_req.wdata;
            m_req.wstrb   = sel_req.wstrb;
            g_rsp.wready  = m_rsp.wready;
         end
         ARB_WR_RESP: begin
            m_req.bready  = sel_req.bready;
            g_rsp.bvalid  = m_rsp.bvalid;
            g_rsp.bresp   = m_rsp.bresp;
         end
         default: ;
      endcase
   end

   // Route slave responses to the granted port only
   assign s0_rsp = grant_q ? '0 : g_rsp;
   assign s1_rsp = grant_q ? g_rsp : '0;

   // Handshakes are gated by state through m_req
   assign ar_hs = m_req.arvalid & m_rsp.arready;
   assign r_hs  = m_rsp.rvalid  & m_req.rready;
   assign aw_hs = m_req.awvalid & m_rsp.awready;
   assign w_hs  = m_req.wvalid  & m_rsp.wready;
   assign b_hs  = m_rsp.bvalid  & m_req.bready;

   // Arbitration FSM; busy/grant outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
         grant_oh_q   <= '0;
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_q      <= pick_winner;
                  last_grant_q <= pick_winner;
                  state_q      <= first_txn_state(win_arvalid, win_awvalid, READ_FIRST);
                  busy_q       <= 1'b1;
                  grant_oh_q   <= pick_winner ? 2'b10 : 2'b01;
               end
            end
            ARB_RD_ADDR: if (ar_hs) state_q <= ARB_RD_DATA;
            ARB_RD_DATA: begin
               if (r_hs) begin
                  state_q    <= ARB_IDLE;
                  busy_q     <= 1'b0;
                  grant_oh_q <= '0;
               end
            end
            ARB_WR_ADDR: if (aw_hs) state_q <= ARB_WR_DATA;
            ARB_WR_DATA: if (w_hs) state_q <= ARB_WR_RESP;
            ARB_WR_RESP: begin
               if (b_hs) begin
                  state_q    <= ARB_IDLE;
                  busy_q     <= 1'b0;
                  grant_oh_q <= '0;
               end
            end
            default: begin
               state_q    <= ARB_IDLE;
               busy_q     <= 1'b0;
               grant_oh_q <= '0;
            end
         endcase
      end
   end

   assign busy_o  = busy_q;
   assign grant_o = grant_oh_q;

endmodule

// File: tb/tb_holy_axi_lite_arbiter.sv
// Directed bench for holy_axi_lite_arbiter: one READ_FIRST=1 instance driven
// through read/write scenarios, plus a READ_FIRST=0 instance for ordering.
module tb_holy_axi_lite_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant, grant2;
   logic       busy, busy2;

   int n_tests = 0;
   int n_fail  = 0;
   int ar_cnt  = 0;
   int r_cnt   = 0;

   logic [31:0] ga, gd, wa, wd;
   logic [1:0]  gg, gr, wg, wb;
   logic [3:0]  ws;
   int          gl, wl;

   axi_lite_if s0_if ();
   axi_lite_if s1_if ();
   axi_lite_if m_if ();
   axi_lite_if t0_if ();
   axi_lite_if t1_if ();
   axi_lite_if tm_if ();

   holy_axi_lite_arbiter #(.READ_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .s0_axi_lite(s0_if), .s1_axi_lite(s1_if),
      .m_axi_lite(m_if), .grant_o(grant), .busy_o(busy)
   );

   holy_axi_lite_arbiter #(.READ_FIRST(1'b0)) dut_wf (
      .clk(clk), .rst_n(rst_n), .s0_axi_lite(t0_if), .s1_axi_lite(t1_if),
      .m_axi_lite(tm_if), .grant_o(grant2), .busy_o(busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_if.arvalid === 1'b1 && m_if.arready === 1'b1) ar_cnt <= ar_cnt + 1;
      if (m_if.rvalid === 1'b1 && m_if.rready === 1'b1) r_cnt <= r_cnt + 1;
   end

   function automatic logic [40:0] s0_outs();
      return {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.bresp,
              s0_if.arready, s0_if.rvalid, s0_if.rdata, s0_if.rresp};
   endfunction
   function automatic logic [40:0] s1_outs();
      return {s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.bresp,
              s1_if.arready, s1_if.rvalid, s1_if.rdata, s1_if.rresp};
   endfunction
   function automatic logic [104:0] m_outs();
      return {m_if.awvalid, m_if.awaddr, m_if.wvalid, m_if.wdata, m_if.wstrb,
              m_if.bready, m_if.arvalid, m_if.araddr, m_if.rready};
   endfunction

   task automatic clear_inputs();
      s0_if.awvalid = 0; s0_if.awaddr = '0; s0_if.wvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0;
      s0_if.bready = 0; s0_if.arvalid = 0; s0_if.araddr = '0; s0_if.rready = 0;
      s1_if.awvalid = 0; s1_if.awaddr = '0; s1_if.wvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0;
      s1_if.bready = 0; s1_if.arvalid = 0; s1_if.araddr = '0; s1_if.rready = 0;
      t0_if.awvalid = 0; t0_if.awaddr = '0; t0_if.wvalid = 0; t0_if.wdata = '0; t0_if.wstrb = '0;
      t0_if.bready = 0; t0_if.arvalid = 0; t0_if.araddr = '0; t0_if.rready = 0;
      t1_if.awvalid = 0; t1_if.awaddr = '0; t1_if.wvalid = 0; t1_if.wdata = '0; t1_if.wstrb = '0;
      t1_if.bready = 0; t1_if.arvalid = 0; t1_if.araddr = '0; t1_if.rready = 0;
      m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = '0;
      m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0;
      tm_if.awready = 0; tm_if.wready = 0; tm_if.bvalid = 0; tm_if.bresp = '0;
      tm_if.arready = 0; tm_if.rvalid = 0; tm_if.rdata = '0; tm_if.rresp = '0;
   endtask

   // Leaves the bench one ns after a rising edge with the DUTs idle
   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One read on the given port against an always-ready slave; reports what
   // the downstream saw, the grant, the returned data and the IDLE latency.
   task automatic rd_txn(input int port, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, output logic [31:0] got_addr,
                         output logic [1:0] got_grant, output logic [31:0] got_data,
                         output logic [1:0] got_resp, output int got_lat);
      if (port == 0) begin s0_if.arvalid = 1'b1; s0_if.araddr = addr; s0_if.rready = 1'b0; end
      else begin s1_if.arvalid = 1'b1; s1_if.araddr = addr; s1_if.rready = 1'b0; end
      m_if.arready = 1'b1;
      got_lat = 0;
      #1;
      while (m_if.arvalid !== 1'b1 && got_lat < 20) begin
         @(posedge clk); #1;
         got_lat++;
      end
      got_addr  = m_if.araddr;
      got_grant = grant;
      @(posedge clk); #1;
      if (port == 0) begin s0_if.arvalid = 1'b0; s0_if.rready = 1'b1; end
      else begin s1_if.arvalid = 1'b0; s1_if.rready = 1'b1; end
      m_if.arready = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = data; m_if.rresp = resp;
      #1;
      got_data = (port == 0) ? s0_if.rdata : s1_if.rdata;
      got_resp = (port == 0) ? s0_if.rresp : s1_if.rresp;
      @(posedge clk); #1;
      m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
      if (port == 0) s0_if.rready = 1'b0; else s1_if.rready = 1'b0;
   endtask

   // One write on the given port; reports downstream AW/W contents and the
   // response seen upstream.
   task automatic wr_txn(input int port, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp,
                         output logic [31:0] got_addr, output logic [1:0] got_grant,
                         output logic [31:0] got_data, output logic [3:0] got_strb,
                         output logic [1:0] got_resp, output int got_lat);
      if (port == 0) begin
         s0_if.awvalid = 1; s0_if.awaddr = addr; s0_if.wvalid = 1; s0_if.wdata = data;
         s0_if.wstrb = strb; s0_if.bready = 1;
      end else begin
         s1_if.awvalid = 1; s1_if.awaddr = addr; s1_if.wvalid = 1; s1_if.wdata = data;
         s1_if.wstrb = strb; s1_if.bready = 1;
      end
      m_if.awready = 1'b1;
      got_lat = 0;
      #1;
      while (m_if.awvalid !== 1'b1 && got_lat < 20) begin
         @(posedge clk); #1;
         got_lat++;
      end
      got_addr  = m_if.awaddr;
      got_grant = grant;
      @(posedge clk); #1;
      if (port == 0) s0_if.awvalid = 1'b0; else s1_if.awvalid = 1'b0;
      m_if.awready = 1'b0; m_if.wready = 1'b1;
      #1;
      got_data = m_if.wdata;
      got_strb = m_if.wstrb;
      @(posedge clk); #1;
      if (port == 0) s0_if.wvalid = 1'b0; else s1_if.wvalid = 1'b0;
      m_if.wready = 1'b0; m_if.bvalid = 1'b1; m_if.bresp = resp;
      #1;
      got_resp = (port == 0) ? s0_if.bresp : s1_if.bresp;
      @(posedge clk); #1;
      m_if.bvalid = 1'b0; m_if.bresp = '0;
      if (port == 0) s0_if.bready = 1'b0; else s1_if.bready = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      m_if.rdata = '1; m_if.rvalid = 1; m_if.arready = 1; m_if.bresp = 2'b11;
      s0_if.arvalid = 1; s1_if.awvalid = 1; s0_if.wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      if (grant !== 2'b00) begin $display("FAIL reset_grant: got %b expected 00", grant); n_fail++; end
      n_tests++;
      if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); n_fail++; end
      n_tests++;
      if (s0_outs() !== '0) begin $display("FAIL reset_s0_outs: got %h expected 0", s0_outs()); n_fail++; end
      n_tests++;
      if (s1_outs() !== '0) begin $display("FAIL reset_s1_outs: got %h expected 0", s1_outs()); n_fail++; end
      n_tests++;
      if (m_outs() !== '0) begin $display("FAIL reset_m_outs: got %h expected 0", m_outs()); n_fail++; end
      n_tests++;
      apply_reset();
   endtask

   task automatic test_single_read();
      apply_reset();
      s0_if.arvalid = 1; s0_if.araddr = 32'h0; m_if.arready = 1;
      #1;
      if (m_if.arvalid !== 1'b0) begin $display("FAIL single_idle_latency: got arvalid %b expected 0", m_if.arvalid); n_fail++; end
      n_tests++;
      @(posedge clk); #1;
      if ({m_if.arvalid, m_if.araddr} !== {1'b1, 32'h0}) begin
         $display("FAIL single_m_ar: got %b/%h expected 1/00000000", m_if.arvalid, m_if.araddr); n_fail++;
      end
      n_tests++;
      if (grant !== 2'b01) begin $display("FAIL single_grant: got %b expected 01", grant); n_fail++; end
      n_tests++;
      if (s0_if.arready !== 1'b1) begin $display("FAIL single_arready: got %b expected 1", s0_if.arready); n_fail++; end
      n_tests++;
      if (s1_outs() !== '0) begin $display("FAIL single_s1_quiet: got %h expected 0", s1_outs()); n_fail++; end
      n_tests++;
      @(posedge clk); #1;
      s0_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h1F; m_if.rresp = 2'b00;
      s0_if.rready = 1;
      #1;
      if ({s0_if.rvalid, s0_if.rdata, s0_if.rresp} !== {1'b1, 32'h1F, 2'b00}) begin
         $display("FAIL single_rdata: got %b/%h/%b expected 1/0000001f/00", s0_if.rvalid, s0_if.rdata, s0_if.rresp); n_fail++;
      end
      n_tests++;
      if (m_if.rready !== 1'b1) begin $display("FAIL single_rready: got %b expected 1", m_if.rready); n_fail++; end
      n_tests++;
      if (s1_outs() !== '0) begin $display("FAIL single_s1_quiet_r: got %h expected 0", s1_outs()); n_fail++; end
      n_tests++;
      @(posedge clk); #1;
      m_if.rvalid = 0; m_if.rdata = '0; s0_if.rready = 0;
      #1;
      if ({busy, grant} !== 3'b000) begin $display("FAIL single_back_idle: got busy %b grant %b expected 0 00", busy, grant); n_fail++; end
      n_tests++;
   endtask

   task automatic test_round_robin();
      apply_reset();
      s0_if.arvalid = 1; s0_if.araddr = 32'h4;
      s1_if.arvalid = 1; s1_if.araddr = 32'h0;
      rd_txn(0, 32'h4, 32'hA0A00004, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, ga, gd} !== {2'b01, 32'h4, 32'hA0A00004} || gl !== 1) begin
         $display("FAIL rr_pair1_first: got grant %b addr %h data %h lat %0d expected 01 4 a0a00004 1", gg, ga, gd, gl); n_fail++;
      end
      n_tests++;
      rd_txn(1, 32'h0, 32'hB1B10000, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, ga, gd} !== {2'b10, 32'h0, 32'hB1B10000} || gl !== 1) begin
         $display("FAIL rr_pair1_second: got grant %b addr %h data %h lat %0d expected 10 0 b1b10000 1", gg, ga, gd, gl); n_fail++;
      end
      n_tests++;
      rd_txn(0, 32'h8, 32'h00000008, 2'b00, ga, gg, gd, gr, gl);
      if (gg !== 2'b01) begin $display("FAIL rr_solo: got grant %b expected 01", gg); n_fail++; end
      n_tests++;
      // last owner is now port 0, so port 1 takes the next tie
      s0_if.arvalid = 1; s0_if.araddr = 32'hC;
      s1_if.arvalid = 1; s1_if.araddr = 32'h10;
      rd_txn(1, 32'h10, 32'h00000010, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, ga} !== {2'b10, 32'h10} || gl !== 1) begin
         $display("FAIL rr_pair2_first: got grant %b addr %h lat %0d expected 10 10 1", gg, ga, gl); n_fail++;
      end
      n_tests++;
      rd_txn(0, 32'hC, 32'h0000000C, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, ga, gd} !== {2'b01, 32'hC, 32'hC} || gl !== 1) begin
         $display("FAIL rr_pair2_second: got grant %b addr %h data %h lat %0d expected 01 c c 1", gg, ga, gd, gl); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_write_then_read();
      apply_reset();
      fork
         wr_txn(1, 32'h0, 32'h0000001F, 4'hF, 2'b00, wa, wg, wd, ws, wb, wl);
         begin
            @(posedge clk); @(posedge clk); #1;
            s0_if.arvalid = 1; s0_if.araddr = 32'h0;
         end
      join
      if ({wg, wa, wd, ws, wb} !== {2'b10, 32'h0, 32'h1F, 4'hF, 2'b00} || wl !== 1) begin
         $display("FAIL wr_p1: got grant %b addr %h data %h strb %h bresp %b lat %0d expected 10 0 1f f 00 1",
                  wg, wa, wd, ws, wb, wl); n_fail++;
      end
      n_tests++;
      rd_txn(0, 32'h0, 32'h0000001F, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, gd, gr} !== {2'b01, 32'h1F, 2'b00} || gl !== 1) begin
         $display("FAIL wr_then_rd: got grant %b data %h resp %b lat %0d expected 01 1f 00 1", gg, gd, gr, gl); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_stall();
      int ar0, r0, bad;
      apply_reset();
      ar0 = ar_cnt; r0 = r_cnt; bad = 0;
      s0_if.arvalid = 1; s0_if.araddr = 32'h8; m_if.arready = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (!(busy === 1'b1 && m_if.arvalid === 1'b1 && m_if.araddr === 32'h8 && s0_if.arready === 1'b0)) bad++;
      end
      if (bad !== 0) begin $display("FAIL stall_ar_hold: got %0d bad cycles expected 0", bad); n_fail++; end
      n_tests++;
      m_if.arready = 1;
      @(posedge clk); #1;
      s0_if.arvalid = 0; m_if.arready = 0; s0_if.rready = 1;
      bad = 0;
      repeat (5) begin
         #1;
         if (!(busy === 1'b1 && s0_if.rvalid === 1'b0 && m_if.rready === 1'b1 && m_if.arvalid === 1'b0)) bad++;
         @(posedge clk); #1;
      end
      if (bad !== 0) begin $display("FAIL stall_r_wait: got %0d bad cycles expected 0", bad); n_fail++; end
      n_tests++;
      m_if.rvalid = 1; m_if.rdata = 32'h12345678; s0_if.rready = 0;
      bad = 0;
      repeat (3) begin
         #1;
         if (!(s0_if.rvalid === 1'b1 && m_if.rready === 1'b0 && busy === 1'b1)) bad++;
         @(posedge clk); #1;
      end
      if (bad !== 0) begin $display("FAIL stall_rready_low: got %0d bad cycles expected 0", bad); n_fail++; end
      n_tests++;
      s0_if.rready = 1;
      #1;
      if (s0_if.rdata !== 32'h12345678) begin $display("FAIL stall_rdata: got %h expected 12345678", s0_if.rdata); n_fail++; end
      n_tests++;
      @(posedge clk); #1;
      m_if.rvalid = 0; m_if.rdata = '0; s0_if.rready = 0;
      #1;
      if (busy !== 1'b0 || (ar_cnt - ar0) !== 1 || (r_cnt - r0) !== 1) begin
         $display("FAIL stall_one_transfer: got busy %b ar %0d r %0d expected 0 1 1", busy, ar_cnt - ar0, r_cnt - r0); n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_dual_valid();
      apply_reset();
      s0_if.awvalid = 1; s0_if.awaddr = 32'h14; s0_if.wvalid = 1; s0_if.wdata = 32'h55;
      s0_if.wstrb = 4'h3; s0_if.bready = 1;
      rd_txn(0, 32'h18, 32'h77, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, ga, gd} !== {2'b01, 32'h18, 32'h77} || gl !== 1) begin
         $display("FAIL rf1_read_first: got grant %b addr %h data %h lat %0d expected 01 18 77 1", gg, ga, gd, gl); n_fail++;
      end
      n_tests++;
      wr_txn(0, 32'h14, 32'h55, 4'h3, 2'b00, wa, wg, wd, ws, wb, wl);
      if ({wg, wa, wd, ws} !== {2'b01, 32'h14, 32'h55, 4'h3} || wl !== 1) begin
         $display("FAIL rf1_write_next: got grant %b addr %h data %h strb %h lat %0d expected 01 14 55 3 1", wg, wa, wd, ws, wl); n_fail++;
      end
      n_tests++;
      // READ_FIRST=0 instance: write goes first
      t0_if.arvalid = 1; t0_if.araddr = 32'h18; t0_if.awvalid = 1; t0_if.awaddr = 32'h14;
      t0_if.wvalid = 1; t0_if.wdata = 32'h55; t0_if.wstrb = 4'hF; t0_if.bready = 1;
      tm_if.awready = 1; tm_if.wready = 1; tm_if.arready = 1;
      @(posedge clk); #1;
      if ({tm_if.awvalid, tm_if.arvalid, tm_if.awaddr} !== {2'b10, 32'h14}) begin
         $display("FAIL rf0_write_first: got aw %b ar %b addr %h expected 1 0 14", tm_if.awvalid, tm_if.arvalid, tm_if.awaddr); n_fail++;
      end
      n_tests++;
      @(posedge clk); #1;
      t0_if.awvalid = 0;
      #1;
      if ({tm_if.wvalid, tm_if.wdata} !== {1'b1, 32'h55}) begin
         $display("FAIL rf0_wdata: got %b/%h expected 1/00000055", tm_if.wvalid, tm_if.wdata); n_fail++;
      end
      n_tests++;
      @(posedge clk); #1;
      t0_if.wvalid = 0; tm_if.bvalid = 1;
      @(posedge clk); #1;
      tm_if.bvalid = 0;
      #1;
      if (tm_if.arvalid !== 1'b0 || busy2 !== 1'b0) begin
         $display("FAIL rf0_bubble: got arvalid %b busy %b expected 0 0", tm_if.arvalid, busy2); n_fail++;
      end
      n_tests++;
      @(posedge clk); #1;
      if ({tm_if.arvalid, tm_if.araddr, grant2} !== {1'b1, 32'h18, 2'b01}) begin
         $display("FAIL rf0_read_next: got %b/%h grant %b expected 1/00000018 01", tm_if.arvalid, tm_if.araddr, grant2); n_fail++;
      end
      n_tests++;
      @(posedge clk); #1;
      t0_if.arvalid = 0; tm_if.rvalid = 1; tm_if.rdata = 32'h99; t0_if.rready = 1;
      #1;
      if (t0_if.rdata !== 32'h99) begin $display("FAIL rf0_rdata: got %h expected 00000099", t0_if.rdata); n_fail++; end
      n_tests++;
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      s1_if.awvalid = 1; s1_if.awaddr = 32'h0; s1_if.wvalid = 1; s1_if.wdata = 32'h1F;
      s1_if.wstrb = 4'hF; s1_if.bready = 1; m_if.awready = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      s1_if.awvalid = 0; m_if.awready = 0; m_if.wready = 1;
      #1;
      if ({busy, m_if.wvalid, s1_if.wready} !== 3'b111) begin
         $display("FAIL mid_pre_wr_data: got busy %b wvalid %b wready %b expected 1 1 1", busy, m_if.wvalid, s1_if.wready); n_fail++;
      end
      n_tests++;
      rst_n = 1'b0;
      #1;
      if ({busy, grant} !== 3'b000) begin $display("FAIL mid_reset_ctrl: got busy %b grant %b expected 0 00", busy, grant); n_fail++; end
      n_tests++;
      if (m_outs() !== '0 || s1_outs() !== '0) begin
         $display("FAIL mid_reset_outs: got m %h s1 %h expected 0 0", m_outs(), s1_outs()); n_fail++;
      end
      n_tests++;
      clear_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      s0_if.arvalid = 1; s0_if.araddr = 32'h0;
      s1_if.arvalid = 1; s1_if.araddr = 32'h4;
      rd_txn(0, 32'h0, 32'hFFFFFFFF, 2'b11, ga, gg, gd, gr, gl);
      if ({gg, gd, gr} !== {2'b01, 32'hFFFFFFFF, 2'b11}) begin
         $display("FAIL mid_first_grant_err: got grant %b data %h resp %b expected 01 ffffffff 11", gg, gd, gr); n_fail++;
      end
      n_tests++;
      rd_txn(1, 32'h4, 32'h0, 2'b00, ga, gg, gd, gr, gl);
      if ({gg, ga} !== {2'b10, 32'h4}) begin
         $display("FAIL mid_second: got grant %b addr %h expected 10 4", gg, ga); n_fail++;
      end
      n_tests++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_then_read();
      test_stall();
      test_dual_valid();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
